zeroriscy_div_seq: RTL

- Multi-cycle sequencer for the RV32M DIV/DIVU/REM/REMU group in the zeroriscy EX stage.
- Drives one shared WIDTH-bit subtractor through a restoring shift-subtract loop, one quotient bit per cycle.
- Handles sign pre-conditioning, post-correction, divide-by-zero and signed-overflow.
- Presents a single valid/ready handshake to the ID/EX controller.

---
 rtl/zeroriscy_div_seq_pkg.sv | 27 ++
 rtl/zeroriscy_div_step.sv | 22 ++
 rtl/zeroriscy_div_seq.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/zeroriscy_div_seq_pkg.sv
// Shared types for the RV32M divide sequencer: funct3[1:0] opcode decode and FSM states.
package zeroriscy_div_seq_pkg;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } div_state_e;

  function automatic logic op_is_signed(input div_op_e op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/zeroriscy_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, subtract if it fits.
module zeroriscy_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dividend_bit,
  output logic [WIDTH-1:0] rem_next,
  output logic             quo_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem, dividend_bit};
  assign diff    = shifted - {1'b0, divisor};

  // Shifted value can exceed WIDTH bits only when it is already larger than any divisor.
  assign quo_bit  = shifted[WIDTH] | ~diff[WIDTH];
  assign rem_next = quo_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/zeroriscy_div_seq.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer driving one shared restoring step.
// Optional macro ZERORISCY_DIV_EARLY_OUT_EN short-cuts divide-by-zero and signed overflow.
module zeroriscy_div_seq
  import zeroriscy_div_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_en_i,
  input  logic [1:0]       div_op_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             kill_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_rem_q;
  logic             a_neg_q;
  logic             b_neg_q;
  logic             q_neg_q;

  div_op_e          op_in;
  logic             in_signed;
  logic             accept;
  logic [WIDTH-1:0] rem_next;
  logic             quo_bit;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign op_in     = div_op_e'(div_op_i);
  assign in_signed = op_is_signed(op_in);
  assign accept    = div_en_i & ready_o & ~kill_i;

  zeroriscy_div_step #(.WIDTH(WIDTH)) u_step (
    .rem          (rem_q),
    .divisor      (b_q),
    .dividend_bit (a_q[WIDTH-1]),
    .rem_next     (rem_next),
    .quo_bit      (quo_bit)
  );

`ifdef ZERORISCY_DIV_EARLY_OUT_EN
  logic             early_q;
  logic [WIDTH-1:0] early_res_q;
  logic             in_b_zero;
  logic             in_ovf;
  logic [WIDTH-1:0] in_early_res;

  assign in_b_zero    = (op_b_i == '0);
  assign in_ovf       = in_signed && (op_a_i == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b_i == '1);
  assign in_early_res = in_b_zero ? (op_is_rem(op_in) ? op_a_i : '1)
                                  : (op_is_rem(op_in) ? '0 : op_a_i);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ready_o  <= 1'b1;
      busy_o   <= 1'b0;
      valid_o  <= 1'b0;
      result_o <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      q_neg_q  <= 1'b0;
`ifdef ZERORISCY_DIV_EARLY_OUT_EN
      early_q     <= 1'b0;
      early_res_q <= '0;
`endif
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            a_q      <= op_a_i;
            b_q      <= op_b_i;
            is_rem_q <= op_is_rem(op_in);
            a_neg_q  <= in_signed & op_a_i[WIDTH-1];
            b_neg_q  <= in_signed & op_b_i[WIDTH-1];
            // A zero divisor must yield all ones regardless of dividend sign.
            q_neg_q  <= in_signed & (op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1]) & (|op_b_i);
`ifdef ZERORISCY_DIV_EARLY_OUT_EN
            early_q     <= in_b_zero | in_ovf;
            early_res_q <= in_early_res;
`endif
            ready_o  <= 1'b0;
            busy_o   <= 1'b1;
            state    <= PREP;
          end
        end
        PREP: begin
          a_q   <= cond_neg(a_q, a_neg_q);
          b_q   <= cond_neg(b_q, b_neg_q);
          rem_q <= '0;
          cnt_q <= CNT_W'(WIDTH - 1);
          state <= ITER;
`ifdef ZERORISCY_DIV_EARLY_OUT_EN
          if (early_q) begin
            result_o <= early_res_q;
            state    <= DONE;
          end
`endif
        end
        ITER: begin
          // Quotient bits fill a_q from the bottom as dividend bits leave the top.
          a_q   <= {a_q[WIDTH-2:0], quo_bit};
          rem_q <= rem_next;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state <= FIX;
        end
        FIX: begin
          result_o <= is_rem_q ? cond_neg(rem_q, a_neg_q) : cond_neg(a_q, q_neg_q);
          state    <= DONE;
        end
        DONE: begin
          valid_o <= 1'b1;
          ready_o <= 1'b1;
          busy_o  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          ready_o <= 1'b1;
          busy_o  <= 1'b0;
          state   <= IDLE;
        end
      endcase

      // Abort wins over any in-flight progress; DONE is allowed to finish its strobe.
      if (kill_i && (state == PREP || state == ITER || state == FIX)) begin
        ready_o <= 1'b1;
        busy_o  <= 1'b0;
        state   <= IDLE;
      end
    end
  end

endmodule
